// File: rtl/sd_host_arbiter.sv
// Arbitrates the single user_io SD-sector host port between two block-device clients,
// one sector transaction at a time, with ack/strobe/data routing to the granted client.
//
//  state | meaning
//  IDLE  | no owner; picks a requester (fixed or round-robin) and latches its LBA/op
//  REQ   | host_rd/host_wr asserted for owner; waits for host_ack, cancel or timeout
//  XFER  | host acked; sector bytes flow until host_ack falls
//  DONE  | waits for owner to drop its request, then frees the port
module sd_host_arbiter #(
   parameter int PRIO_FIXED = 0,
   parameter int TMO_W      = 24,
   parameter int TMO_EN     = 1
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        c0_rd,
   input  logic        c0_wr,
   input  logic [31:0] c0_lba,
   input  logic [7:0]  c0_buff_din,
   output logic        c0_ack,
   output logic        c0_buff_wr,
   input  logic        c1_rd,
   input  logic        c1_wr,
   input  logic [31:0] c1_lba,
   input  logic [7:0]  c1_buff_din,
   output logic        c1_ack,
   output logic        c1_buff_wr,
   output logic [1:0]  host_rd,
   output logic [1:0]  host_wr,
   output logic [31:0] host_lba,
   input  logic        host_ack,
   input  logic        host_buff_wr,
   output logic [7:0]  host_buff_din,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

   localparam logic [TMO_W-1:0] TMO_MAX = '1;

   state_t             state, state_nxt;
   logic [1:0]         grant_nxt, host_rd_nxt, host_wr_nxt;
   logic [31:0]        host_lba_nxt;
   logic               rr_ptr, rr_ptr_nxt;
   logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
   logic               timeout_err_nxt;
   logic               req0, req1, owner_req, sel, sel_rd;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         grant       <= 2'b00;
         host_rd     <= 2'b00;
         host_wr     <= 2'b00;
         host_lba    <= 32'd0;
         rr_ptr      <= 1'b0;
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         host_rd     <= host_rd_nxt;
         host_wr     <= host_wr_nxt;
         host_lba    <= host_lba_nxt;
         rr_ptr      <= rr_ptr_nxt;
         tmo_cnt     <= tmo_cnt_nxt;
         timeout_err <= timeout_err_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant;
      host_rd_nxt     = host_rd;
      host_wr_nxt     = host_wr;
      host_lba_nxt    = host_lba;
      rr_ptr_nxt      = rr_ptr;
      tmo_cnt_nxt     = tmo_cnt;
      timeout_err_nxt = 1'b0;

      req0      = c0_rd | c0_wr;
      req1      = c1_rd | c1_wr;
      owner_req = grant[1] ? req1 : req0;

      // sel = 1 picks client 1; ties go to client 0 or the round-robin pointer
      if (req0 && req1)
         sel = (PRIO_FIXED == 0) ? rr_ptr : 1'b0;
      else
         sel = req1;
      sel_rd = sel ? c1_rd : c0_rd;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant_nxt    = sel ? 2'b10 : 2'b01;
               host_lba_nxt = sel ? c1_lba : c0_lba;
               host_rd_nxt  = sel_rd ? grant_nxt : 2'b00;
               host_wr_nxt  = sel_rd ? 2'b00 : grant_nxt;
               tmo_cnt_nxt  = '0;
               state_nxt    = REQ;
            end
         end
         REQ: begin
            if (host_ack) begin
               host_rd_nxt = 2'b00;
               host_wr_nxt = 2'b00;
               state_nxt   = XFER;
            end else if (!owner_req) begin
               host_rd_nxt = 2'b00;
               host_wr_nxt = 2'b00;
               grant_nxt   = 2'b00;
               state_nxt   = IDLE;
            end else if ((TMO_EN != 0) && (tmo_cnt == TMO_MAX - 1'b1)) begin
               host_rd_nxt     = 2'b00;
               host_wr_nxt     = 2'b00;
               timeout_err_nxt = 1'b1;
               state_nxt       = DONE;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
         end
         XFER: begin
            if (!host_ack)
               state_nxt = DONE;
         end
         DONE: begin
            // holding off until the request drops prevents re-serving the same request
            if (!owner_req) begin
               grant_nxt  = 2'b00;
               rr_ptr_nxt = grant[0];
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy          = (state != IDLE);
   assign c0_ack        = host_ack & grant[0];
   assign c1_ack        = host_ack & grant[1];
   assign c0_buff_wr    = host_buff_wr & grant[0];
   assign c1_buff_wr    = host_buff_wr & grant[1];
   assign host_buff_din = grant[1] ? c1_buff_din : (grant[0] ? c0_buff_din : 8'h00);

endmodule

// File: tb/tb_sd_host_arbiter.sv
// Scoreboard bench for sd_host_arbiter: stimulus queues expected host commands and
// routed bytes, a negedge monitor pops and compares them as the DUT presents them.
module tb_sd_host_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        c0_rd = 0, c0_wr = 0, c1_rd = 0, c1_wr = 0;
   logic [31:0] c0_lba = 0, c1_lba = 0;
   logic [7:0]  c0_buff_din = 0, c1_buff_din = 0;
   logic        c0_ack, c0_buff_wr, c1_ack, c1_buff_wr;
   logic [1:0]  host_rd, host_wr, grant;
   logic [31:0] host_lba;
   logic        host_ack = 0, host_buff_wr = 0;
   logic [7:0]  host_buff_din;
   logic        busy, timeout_err;

   sd_host_arbiter #(.PRIO_FIXED(0), .TMO_W(4), .TMO_EN(1)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .c0_rd(c0_rd), .c0_wr(c0_wr), .c0_lba(c0_lba), .c0_buff_din(c0_buff_din),
      .c0_ack(c0_ack), .c0_buff_wr(c0_buff_wr),
      .c1_rd(c1_rd), .c1_wr(c1_wr), .c1_lba(c1_lba), .c1_buff_din(c1_buff_din),
      .c1_ack(c1_ack), .c1_buff_wr(c1_buff_wr),
      .host_rd(host_rd), .host_wr(host_wr), .host_lba(host_lba),
      .host_ack(host_ack), .host_buff_wr(host_buff_wr), .host_buff_din(host_buff_din),
      .grant(grant), .busy(busy), .timeout_err(timeout_err)
   );

   always #10 clk_sys = ~clk_sys;

   typedef struct {
      logic [1:0]  g;
      logic [1:0]  rd;
      logic [1:0]  wr;
      logic [31:0] lba;
   } cmd_t;

   cmd_t       exp_q[$];
   logic [9:0] byte_q[$];
   int         n_vec = 0;
   int         n_miss = 0;
   int         bw0_cnt = 0;
   int         bw1_cnt = 0;
   logic [1:0] prev_cmd = 2'b00;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endfunction

   function automatic void push_cmd(logic [1:0] g, logic [1:0] rd, logic [1:0] wr,
                                    logic [31:0] lba);
      cmd_t c;
      c.g = g; c.rd = rd; c.wr = wr; c.lba = lba;
      exp_q.push_back(c);
   endfunction

   always @(negedge clk_sys) begin
      cmd_t       e;
      logic [9:0] b;
      if (((host_rd | host_wr) != 2'b00) && (prev_cmd == 2'b00)) begin
         if (exp_q.size() == 0) begin
            chk("cmd_unexpected", {28'd0, host_rd, host_wr}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("cmd_grant", {30'd0, grant}, {30'd0, e.g});
            chk("cmd_host_rd", {30'd0, host_rd}, {30'd0, e.rd});
            chk("cmd_host_wr", {30'd0, host_wr}, {30'd0, e.wr});
            chk("cmd_host_lba", host_lba, e.lba);
         end
      end
      prev_cmd = host_rd | host_wr;
      if (c0_buff_wr) bw0_cnt++;
      if (c1_buff_wr) bw1_cnt++;
      if (c0_buff_wr || c1_buff_wr) begin
         if (byte_q.size() == 0) begin
            chk("byte_unexpected", {30'd0, c1_buff_wr, c0_buff_wr}, 32'd0);
         end else begin
            b = byte_q.pop_front();
            chk("byte_route", {30'd0, c1_buff_wr, c0_buff_wr}, {30'd0, b[9:8]});
            chk("byte_din", {24'd0, host_buff_din}, {24'd0, b[7:0]});
         end
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 0;
      c0_rd = 0; c0_wr = 0; c1_rd = 0; c1_wr = 0;
      host_ack = 0; host_buff_wr = 0;
      repeat (2) tick();
      reset_n = 1;
      tick();
   endtask

   task automatic wait_cmd(input string nm);
      int n = 0;
      while (((host_rd | host_wr) == 2'b00) && (n < 20)) begin
         tick();
         n++;
      end
      chk(nm, {31'd0, ((host_rd | host_wr) != 2'b00)}, 32'd1);
   endtask

   task automatic finish_xfer(input int ack_cycles);
      host_ack = 1;
      repeat (ack_cycles) tick();
      host_ack = 0;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      int seen;

      // reset state
      do_reset();
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_host_rd", {30'd0, host_rd}, 32'd0);
      chk("rst_host_wr", {30'd0, host_wr}, 32'd0);
      chk("rst_host_lba", host_lba, 32'd0);
      chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
      chk("rst_buff_din", {24'd0, host_buff_din}, 32'd0);

      // host activity while idle is not routed
      c0_buff_din = 8'h11;
      host_ack = 1; host_buff_wr = 1;
      #1;
      chk("idle_c0_ack", {31'd0, c0_ack}, 32'd0);
      chk("idle_c1_ack", {31'd0, c1_ack}, 32'd0);
      chk("idle_bw", {30'd0, c1_buff_wr, c0_buff_wr}, 32'd0);
      chk("idle_din", {24'd0, host_buff_din}, 32'd0);
      host_ack = 0; host_buff_wr = 0;

      // T1: single read from client 0
      c0_lba = 32'h0000_0123; c0_rd = 1;
      push_cmd(2'b01, 2'b01, 2'b00, 32'h0000_0123);
      tick();
      chk("t1_host_rd", {30'd0, host_rd}, 32'd1);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      c0_lba = 32'hFFFF_FFFF;
      host_ack = 1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("t1_c0_ack", {31'd0, c0_ack}, 32'd1);
         chk("t1_c1_ack", {31'd0, c1_ack}, 32'd0);
         tick();
      end
      chk("t1_rd_cleared", {30'd0, host_rd}, 32'd0);
      chk("t1_lba_stable", host_lba, 32'h0000_0123);
      host_ack = 0;
      #1;
      chk("t1_c0_ack_low", {31'd0, c0_ack}, 32'd0);
      tick();
      tick();
      chk("t1_grant_held", {30'd0, grant}, 32'd1);
      c0_rd = 0;
      tick();
      chk("t1_grant_free", {30'd0, grant}, 32'd0);
      chk("t1_busy_free", {31'd0, busy}, 32'd0);

      // T2: round robin
      do_reset();
      c0_lba = 32'hA000_0000; c0_rd = 1;
      c1_lba = 32'hB000_0000; c1_wr = 1;
      push_cmd(2'b01, 2'b01, 2'b00, 32'hA000_0000);
      push_cmd(2'b10, 2'b00, 2'b10, 32'hB000_0000);
      tick();
      chk("t2_first_c0", {30'd0, grant}, 32'd1);
      finish_xfer(3);
      c0_rd = 0;
      wait_cmd("t2_wait_c1");
      chk("t2_second_c1", {30'd0, grant}, 32'd2);
      finish_xfer(2);
      c1_wr = 0;
      tick();
      c0_lba = 32'hA000_0001; c0_rd = 1;
      push_cmd(2'b01, 2'b01, 2'b00, 32'hA000_0001);
      tick();
      finish_xfer(2);
      c0_rd = 0;
      tick();
      c0_lba = 32'hA000_0002; c0_rd = 1;
      c1_lba = 32'hB000_0002; c1_wr = 1;
      push_cmd(2'b10, 2'b00, 2'b10, 32'hB000_0002);
      push_cmd(2'b01, 2'b01, 2'b00, 32'hA000_0002);
      tick();
      chk("t2_rr_c1_first", {30'd0, grant}, 32'd2);
      finish_xfer(2);
      c1_wr = 0;
      wait_cmd("t2_wait_c0");
      chk("t2_rr_c0_second", {30'd0, grant}, 32'd1);
      finish_xfer(2);
      c0_rd = 0;
      tick();
      chk("t2_idle", {31'd0, busy}, 32'd0);

      // T3: 512 byte strobes to client 1
      c0_buff_din = 8'hAA; c1_buff_din = 8'h55;
      c1_lba = 32'h0000_3000; c1_rd = 1;
      push_cmd(2'b10, 2'b10, 2'b00, 32'h0000_3000);
      tick();
      host_ack = 1;
      tick();
      bw0_cnt = 0; bw1_cnt = 0;
      c1_lba = 32'h0000_9999;
      host_buff_wr = 1;
      for (int i = 0; i < 512; i++) begin
         byte_q.push_back({2'b10, 8'h55});
         tick();
      end
      host_buff_wr = 0;
      @(negedge clk_sys);
      #1;
      chk("t3_c1_strobes", bw1_cnt, 512);
      chk("t3_c0_strobes", bw0_cnt, 0);
      chk("t3_lba_stable", host_lba, 32'h0000_3000);
      tick();
      host_ack = 0;
      tick();
      c1_rd = 0;
      tick();
      chk("t3_idle", {31'd0, busy}, 32'd0);

      // T4: ack timeout after 15 cycles in REQ
      c0_lba = 32'h0000_0044; c0_wr = 1;
      push_cmd(2'b01, 2'b00, 2'b01, 32'h0000_0044);
      tick();
      hi = (host_wr == 2'b01) ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (host_wr != 2'b01) break;
         hi++;
      end
      chk("t4_wr_cycles", hi, 15);
      chk("t4_timeout_pulse", {31'd0, timeout_err}, 32'd1);
      tick();
      chk("t4_timeout_one_cyc", {31'd0, timeout_err}, 32'd0);
      chk("t4_busy_done", {31'd0, busy}, 32'd1);
      c0_wr = 0;
      tick();
      chk("t4_idle", {31'd0, busy}, 32'd0);
      chk("t4_grant_free", {30'd0, grant}, 32'd0);

      // T5: async reset mid-XFER
      c1_lba = 32'h0000_0055; c1_rd = 1;
      push_cmd(2'b10, 2'b10, 2'b00, 32'h0000_0055);
      tick();
      host_ack = 1;
      tick();
      tick();
      #2;
      reset_n = 0;
      #1;
      chk("t5_grant", {30'd0, grant}, 32'd0);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_host_cmd", {28'd0, host_rd, host_wr}, 32'd0);
      chk("t5_host_lba", host_lba, 32'd0);
      chk("t5_c1_ack", {31'd0, c1_ack}, 32'd0);
      tick();
      reset_n = 1; host_ack = 0;
      push_cmd(2'b10, 2'b10, 2'b00, 32'h0000_0055);
      tick();
      chk("t5_regrant", {30'd0, grant}, 32'd2);
      finish_xfer(1);
      c1_rd = 0;
      tick();

      // T6: cancel in REQ; pointer must not move on cancel
      c0_lba = 32'h0000_0066; c0_rd = 1;
      push_cmd(2'b01, 2'b01, 2'b00, 32'h0000_0066);
      tick();
      chk("t6_host_rd", {30'd0, host_rd}, 32'd1);
      c0_rd = 0;
      tick();
      chk("t6_rd_cleared", {30'd0, host_rd}, 32'd0);
      chk("t6_grant_free", {30'd0, grant}, 32'd0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (timeout_err) seen = 1;
         tick();
      end
      chk("t6_no_timeout", seen, 0);
      c0_lba = 32'h0000_0077; c0_rd = 1;
      c1_lba = 32'h0000_0088; c1_rd = 1;
      push_cmd(2'b01, 2'b01, 2'b00, 32'h0000_0077);
      push_cmd(2'b10, 2'b10, 2'b00, 32'h0000_0088);
      tick();
      chk("t6_ptr_kept", {30'd0, grant}, 32'd1);
      finish_xfer(1);
      c0_rd = 0;
      wait_cmd("t6_wait_c1");
      finish_xfer(1);
      c1_rd = 0;
      tick();
      tick();

      chk("cmd_queue_drained", exp_q.size(), 0);
      chk("byte_queue_drained", byte_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
